flopr_pipe: RTL and testbench



---
 rtl/flopr_pipe.sv | 110 +++++++++++
 tb/tb_flopr_pipe.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/flopr_pipe.sv
// Elastic DEPTH-stage pipeline register with valid/ready handshake, backpressure and flush.
// Optional occupancy counter output is enabled by defining FLOPR_PIPE_OCC_EN.
module flopr_pipe #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FLOPR_PIPE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH:0]   adv;
    logic             in_fire;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        logic carry;
        carry      = out_ready;
        adv        = '0;
        adv[DEPTH] = carry;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            carry  = ~v_q[i] | carry;
            adv[i] = carry;
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = d_q[DEPTH-1];

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (adv[0]) begin
            v_d[0] = in_fire;
            if (in_fire) begin
                d_d[0] = in_data;
            end
        end
        // Bubbles move forward but never overwrite the data a stage already holds.
        for (int i = 1; i < DEPTH; i++) begin
            if (adv[i]) begin
                v_d[i] = v_q[i-1];
                if (v_q[i-1]) begin
                    d_d[i] = d_q[i-1];
                end
            end
        end
        if (flush) begin
            v_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

`ifdef FLOPR_PIPE_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [OCC_W-1:0] occ_q, occ_d;
    logic             out_fire;

    assign out_fire = out_valid & out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_fire && !out_fire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_fire && out_fire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
// Directed self-checking bench for flopr_pipe: a 64-bit/2-stage instance and a 32-bit/4-stage instance.
module tb_flopr_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Instance A: WIDTH=64, DEPTH=2
    logic        a_reset = 0, a_flush = 0, a_in_valid = 0, a_out_ready = 0;
    logic        a_in_ready, a_out_valid;
    logic [63:0] a_in_data = '0, a_out_data;
    // Instance B: WIDTH=32, DEPTH=4
    logic        b_reset = 0, b_flush = 0, b_in_valid = 0, b_out_ready = 0;
    logic        b_in_ready, b_out_valid;
    logic [31:0] b_in_data = '0, b_out_data;
`ifdef FLOPR_PIPE_OCC_EN
    logic [1:0]  a_occ;
    logic [2:0]  b_occ;
`endif

    flopr_pipe #(.WIDTH(64), .DEPTH(2)) u_a (
        .clk(clk), .reset(a_reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
`ifdef FLOPR_PIPE_OCC_EN
        , .occ(a_occ)
`endif
    );

    flopr_pipe #(.WIDTH(32), .DEPTH(4)) u_b (
        .clk(clk), .reset(b_reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
`ifdef FLOPR_PIPE_OCC_EN
        , .occ(b_occ)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1; b_reset = 1;
        step(); step();
        a_reset = 0; b_reset = 0;
        #1;
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_out_valid got %0b want 0", a_out_valid); end
        n_tests++; if (a_out_data !== 64'd0) begin n_fail++; $display("FAIL rst_a_out_data got %0h want 0", a_out_data); end
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_in_ready got %0b want 1", a_in_ready); end
        n_tests++; if (b_out_valid !== 1'b0 || b_out_data !== 32'd0) begin n_fail++; $display("FAIL rst_b_out got v=%0b d=%0h want v=0 d=0", b_out_valid, b_out_data); end
`ifdef FLOPR_PIPE_OCC_EN
        n_tests++; if (a_occ !== 2'd0 || b_occ !== 3'd0) begin n_fail++; $display("FAIL rst_occ got a=%0d b=%0d want 0 0", a_occ, b_occ); end
`endif
    endtask

    task automatic test_back_to_back();
        a_out_ready = 1;
        a_in_valid = 1; a_in_data = 64'd1;
        step();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_c1_valid got %0b want 0", a_out_valid); end
        a_in_data = 64'd2;
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd1) begin n_fail++; $display("FAIL b2b_c2 got v=%0b d=%0d want v=1 d=1", a_out_valid, a_out_data); end
        a_in_data = 64'd3;
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd2) begin n_fail++; $display("FAIL b2b_c3 got v=%0b d=%0d want v=1 d=2", a_out_valid, a_out_data); end
        a_in_valid = 0;
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd3) begin n_fail++; $display("FAIL b2b_c4 got v=%0b d=%0d want v=1 d=3", a_out_valid, a_out_data); end
        step();
        n_tests++; if (a_out_valid !== 1'b0 || a_out_data !== 64'd3) begin n_fail++; $display("FAIL b2b_empty got v=%0b d=%0d want v=0 d=3", a_out_valid, a_out_data); end
        a_out_ready = 0;
    endtask

    task automatic test_backpressure();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 64'd5;
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rdy5 got %0b want 1", a_in_ready); end
        step();
        a_in_data = 64'd6;
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_rdy6 got %0b want 1", a_in_ready); end
        step();
        a_in_data = 64'd7;
        #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_rdy got %0b want 0", a_in_ready); end
`ifdef FLOPR_PIPE_OCC_EN
        n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ_full got %0d want 2", a_occ); end
`endif
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd5) begin n_fail++; $display("FAIL bp_stall got v=%0b d=%0d want v=1 d=5", a_out_valid, a_out_data); end
        a_out_ready = 1;
        step();
        a_in_valid = 0;
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd6) begin n_fail++; $display("FAIL bp_out6 got v=%0b d=%0d want v=1 d=6", a_out_valid, a_out_data); end
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd7) begin n_fail++; $display("FAIL bp_out7 got v=%0b d=%0d want v=1 d=7", a_out_valid, a_out_data); end
        step();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %0b want 0", a_out_valid); end
        a_out_ready = 0;
    endtask

    task automatic test_full_passthrough();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 64'd20;
        step();
        a_in_data = 64'd21;
        step();
        a_out_ready = 1; a_in_data = 64'd8;
        #1;
        n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL full_fire_rdy got %0b want 1", a_in_ready); end
        step();
        a_in_valid = 0;
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd21) begin n_fail++; $display("FAIL full_fire_out got v=%0b d=%0d want v=1 d=21", a_out_valid, a_out_data); end
`ifdef FLOPR_PIPE_OCC_EN
        n_tests++; if (a_occ !== 2'd2) begin n_fail++; $display("FAIL full_fire_occ got %0d want 2", a_occ); end
`endif
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd8) begin n_fail++; $display("FAIL full_fire_out8 got v=%0b d=%0d want v=1 d=8", a_out_valid, a_out_data); end
        step();
        a_out_ready = 0;
    endtask

    task automatic test_flush();
        a_out_ready = 0;
        a_in_valid = 1; a_in_data = 64'd9;
        step();
        a_in_data = 64'd10;
        step();
        a_flush = 1; a_out_ready = 1; a_in_data = 64'd11;
        #1;
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_rdy got %0b want 0", a_in_ready); end
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd9) begin n_fail++; $display("FAIL flush_cycle_out got v=%0b d=%0d want v=1 d=9", a_out_valid, a_out_data); end
        step();
        a_flush = 0; a_in_valid = 0;
        n_tests++; if (a_out_valid !== 1'b0 || a_out_data !== 64'd10) begin n_fail++; $display("FAIL flush_after got v=%0b d=%0d want v=0 d=10", a_out_valid, a_out_data); end
`ifdef FLOPR_PIPE_OCC_EN
        n_tests++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL flush_occ got %0d want 0", a_occ); end
`endif
        step(); step();
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no11 got %0b want 0", a_out_valid); end
        a_in_valid = 1; a_in_data = 64'd12;
        step();
        a_in_valid = 0;
        step();
        n_tests++; if (a_out_valid !== 1'b1 || a_out_data !== 64'd12) begin n_fail++; $display("FAIL flush_next12 got v=%0b d=%0d want v=1 d=12", a_out_valid, a_out_data); end
        step();
        a_out_ready = 0;
    endtask

    task automatic test_wide_deep();
        b_out_ready = 1;
        b_in_valid = 1; b_in_data = 32'hFFFF_FFFF;
        step();
        b_in_valid = 0;
        step(); step();
        n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL deep_c3_valid got %0b want 0", b_out_valid); end
        step();
        n_tests++; if (b_out_valid !== 1'b1 || b_out_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL deep_c4 got v=%0b d=%0h want v=1 d=ffffffff", b_out_valid, b_out_data); end
        step();
        n_tests++; if (b_out_valid !== 1'b0 || b_out_data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL deep_retain got v=%0b d=%0h want v=0 d=ffffffff", b_out_valid, b_out_data); end
        b_in_valid = 1; b_in_data = 32'h1234_5678;
        step();
        b_in_valid = 0;
        step();
        b_reset = 1;
        step();
        b_reset = 0;
        #1;
        n_tests++; if (b_out_valid !== 1'b0 || b_out_data !== 32'd0) begin n_fail++; $display("FAIL deep_midrst got v=%0b d=%0h want v=0 d=0", b_out_valid, b_out_data); end
        step(); step(); step();
        n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL deep_discard got %0b want 0", b_out_valid); end
        n_tests++; if (b_in_ready !== 1'b1) begin n_fail++; $display("FAIL deep_rdy got %0b want 1", b_in_ready); end
        b_out_ready = 0;
    endtask

    initial begin
        step();
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_full_passthrough();
        test_flush();
        test_wide_deep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
